uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 63 ++++++
 tb/tb_uart_tx_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: channel request and transmitter handshake bundle for the UART TX arbiter
interface uart_tx_arbiter_if;
  logic [3:0] req_valid;
  logic [31:0] req_data;
  logic [3:0] req_ack;
  logic [3:0] chan_done;
  logic [7:0] tx_data;
  logic tx_start;
  logic tx_busy;
  logic tx_done;
  logic [1:0] active_chan;
  logic ctrl_busy;
  logic timeout_err;
  logic err_clr;
  modport master (
    output req_valid, req_data, tx_busy, tx_done, err_clr,
    input req_ack, chan_done, tx_data, tx_start, active_chan, ctrl_busy, timeout_err
  );
  modport slave (
    input req_valid, req_data, tx_busy, tx_done, err_clr,
    output req_ack, chan_done, tx_data, tx_start, active_chan, ctrl_busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding four byte channels into one UART transmitter, with transfer timeout
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input logic clk,
  input logic rst_n,
  uart_tx_arbiter_if.slave b
);
  typedef enum logic [1:0] {IDLE, WAIT_ACCEPT, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [19:0] cnt, cnt_n;
  logic [1:0] ptr, ptr_n, win, chan_n;
  logic [7:0] data_n;
  logic [3:0] ack_n, done_n;
  logic hit, grant, done, expire, err_n;
  // descending scan so the lowest offset from ptr is the final winner
  always_comb begin
    win = ptr;
    hit = 1'b0;
    for (int i = 3; i >= 0; i--)
      if (b.req_valid[ptr + 2'(i)]) begin
        win = ptr + 2'(i);
        hit = 1'b1;
      end
  end
  assign grant = state == IDLE && hit && !b.tx_busy;
  assign done = state == WAIT_DONE && b.tx_done;
  assign expire = state != IDLE && !done && cnt == 20'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_n = grant ? WAIT_ACCEPT : (done || expire) ? IDLE : (state == WAIT_ACCEPT && b.tx_busy) ? WAIT_DONE : state;
    cnt_n = grant ? '0 : state != IDLE ? cnt + 20'd1 : cnt;
    ptr_n = grant ? win + 2'd1 : ptr;
    chan_n = grant ? win : b.active_chan;
    data_n = grant ? b.req_data[{win, 3'b000} +: 8] : b.tx_data;
    ack_n = grant ? 4'b0001 << win : 4'b0000;
    done_n = done ? 4'b0001 << b.active_chan : 4'b0000;
    err_n = expire || (b.timeout_err && !b.err_clr);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      b.tx_start <= 1'b0;
      b.tx_data <= 8'h00;
      b.req_ack <= 4'b0000;
      b.chan_done <= 4'b0000;
      b.active_chan <= 2'd0;
      b.ctrl_busy <= 1'b0;
      b.timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ptr <= ptr_n;
      b.tx_start <= grant;
      b.tx_data <= data_n;
      b.req_ack <= ack_n;
      b.chan_done <= done_n;
      b.active_chan <= chan_n;
      b.ctrl_busy <= state_n != IDLE;
      b.timeout_err <= err_n;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic against a transaction-level reference model
module tb_uart_tx_arbiter;
  localparam int T = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  uart_tx_arbiter_if b();
  uart_tx_arbiter #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .rst_n(rst_n), .b(b));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_start"}, b.tx_start, 0);
    chk({t, "_data"}, b.tx_data, 0);
    chk({t, "_ack"}, b.req_ack, 0);
    chk({t, "_done"}, b.chan_done, 0);
    chk({t, "_chan"}, b.active_chan, 0);
    chk({t, "_busy"}, b.ctrl_busy, 0);
    chk({t, "_err"}, b.timeout_err, 0);
  endtask

  task automatic do_reset();
    b.req_valid = '0;
    b.req_data = '0;
    b.tx_busy = 1'b0;
    b.tx_done = 1'b0;
    b.err_clr = 1'b0;
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input string t);
    for (int n = 0; n < 10 && b.tx_start !== 1'b1; n++) tick();
    chk(t, b.tx_start, 1);
  endtask

  initial begin
    int n, rr, own, age, k, pd;
    logic [3:0] seen, pend, e_ack, e_done;
    logic [31:0] dat;
    logic [7:0] e_data;
    bit inx, acc, err, e_start, set_err, tb, td, cl;
    b.req_valid = '0;
    b.req_data = '0;
    b.tx_busy = 1'b0;
    b.tx_done = 1'b0;
    b.err_clr = 1'b0;
    #3 chk_reset("por");
    tick();
    rst_n = 1'b1;
    // single request on channel 2
    b.req_data = 32'h00A5_0000;
    b.req_valid = 4'b0100;
    tick();
    chk("s_start", b.tx_start, 1);
    chk("s_data", b.tx_data, 8'hA5);
    chk("s_ack", b.req_ack, 4'b0100);
    chk("s_chan", b.active_chan, 2);
    chk("s_busy", b.ctrl_busy, 1);
    b.req_valid = '0;
    b.tx_busy = 1'b1;
    tick();
    chk("s_start_w", b.tx_start, 0);
    chk("s_ack_w", b.req_ack, 0);
    b.tx_done = 1'b1;
    tick();
    chk("s_done", b.chan_done, 4'b0100);
    chk("s_idle", b.ctrl_busy, 0);
    chk("s_hold", b.tx_data, 8'hA5);
    b.tx_done = 1'b0;
    b.tx_busy = 1'b0;
    tick();
    chk("s_done_once", b.chan_done, 0);
    // fairness with all channels requesting
    do_reset();
    b.req_data = 32'h4433_2211;
    b.req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_start("rr_start");
      chk("rr_chan", b.active_chan, i % 4);
      chk("rr_ack", b.req_ack, 1 << (i % 4));
      chk("rr_data", b.tx_data, (i % 4 + 1) * 17);
      b.tx_busy = 1'b1;
      tick();
      b.tx_done = 1'b1;
      tick();
      b.tx_done = 1'b0;
      b.tx_busy = 1'b0;
    end
    // transmitter busy blocks arbitration
    do_reset();
    b.tx_busy = 1'b1;
    b.req_valid = 4'b0001;
    b.req_data = 32'h0000_005A;
    repeat (5) begin
      tick();
      chk("blk_start", b.tx_start, 0);
    end
    b.tx_busy = 1'b0;
    tick();
    chk("blk_grant", b.tx_start, 1);
    chk("blk_chan", b.active_chan, 0);
    // timeout with transmitter never responding
    do_reset();
    b.req_valid = 4'b0010;
    b.req_data = 32'h0000_C300;
    tick();
    chk("to_start", b.tx_start, 1);
    b.req_valid = '0;
    n = 0;
    seen = '0;
    while (b.ctrl_busy && n < 100) begin
      tick();
      n++;
      seen |= b.chan_done;
    end
    chk("to_len", n, T);
    chk("to_err", b.timeout_err, 1);
    chk("to_nodone", seen, 0);
    repeat (3) tick();
    chk("to_sticky", b.timeout_err, 1);
    b.err_clr = 1'b1;
    tick();
    b.err_clr = 1'b0;
    chk("to_clr", b.timeout_err, 0);
    // completion on the same edge the timeout would fire
    do_reset();
    b.req_valid = 4'b0010;
    b.req_data = 32'h0000_7E00;
    tick();
    b.req_valid = '0;
    b.tx_busy = 1'b1;
    repeat (T - 1) tick();
    chk("race_busy", b.ctrl_busy, 1);
    b.tx_done = 1'b1;
    tick();
    chk("race_done", b.chan_done, 4'b0010);
    chk("race_err", b.timeout_err, 0);
    b.tx_done = 1'b0;
    b.tx_busy = 1'b0;
    // asynchronous reset in the middle of a transfer
    do_reset();
    b.req_valid = 4'b0001;
    b.req_data = 32'h0000_00FF;
    tick();
    b.req_valid = '0;
    b.tx_busy = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 chk_reset("mid");
    b.tx_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    b.req_valid = 4'b1000;
    b.req_data = 32'h9600_0000;
    tick();
    chk("post_start", b.tx_start, 1);
    chk("post_chan", b.active_chan, 3);
    chk("post_data", b.tx_data, 8'h96);
    chk("post_ack", b.req_ack, 4'b1000);
    // randomized traffic against the reference model
    do_reset();
    pend = '0;
    dat = '0;
    rr = 0;
    own = 0;
    age = 0;
    inx = 0;
    acc = 0;
    err = 0;
    e_data = '0;
    for (int c = 0; c < 3000; c++) begin
      pd = ((c / 500) % 2 == 1) ? 40 : 4;
      tb = $urandom_range(0, 3) == 0;
      td = $urandom_range(0, pd - 1) == 0;
      cl = $urandom_range(0, 9) == 0;
      b.req_valid = pend;
      b.req_data = dat;
      b.tx_busy = tb;
      b.tx_done = td;
      b.err_clr = cl;
      tick();
      e_start = 0;
      e_ack = '0;
      e_done = '0;
      set_err = 0;
      if (!inx) begin
        if (pend != 0 && !tb) begin
          k = rr;
          while (!pend[k]) k = (k + 1) % 4;
          own = k;
          e_start = 1;
          e_ack = 4'b0001 << k;
          e_data = dat[8 * k +: 8];
          inx = 1;
          age = 0;
          acc = 0;
          rr = (k + 1) % 4;
        end
      end else begin
        age++;
        if (acc && td) begin
          e_done = 4'b0001 << own;
          inx = 0;
        end else if (age == T) begin
          inx = 0;
          set_err = 1;
        end else if (tb) acc = 1;
      end
      err = set_err ? 1'b1 : (cl ? 1'b0 : err);
      chk("r_start", b.tx_start, e_start);
      chk("r_ack", b.req_ack, e_ack);
      chk("r_done", b.chan_done, e_done);
      chk("r_chan", b.active_chan, own);
      chk("r_data", b.tx_data, e_data);
      chk("r_busy", b.ctrl_busy, inx);
      chk("r_err", b.timeout_err, err);
      if (e_start) pend[own] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          dat[8 * i +: 8] = 8'($urandom);
        end else if (pend[i] && inx && $urandom_range(0, 19) == 0) pend[i] = 1'b0;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
